// File: rtl/npu_sort_pkg.sv
// rtl/npu_sort_pkg.sv - shared sort-path types and width defaults
// Purpose: default widths for the sort output path and the store FSM state type.
// Ports: none (package).
package npu_sort_pkg;

  localparam int ADDR_W_DEF     = 13;
  localparam int DATA_W_DEF     = 16;
  localparam int FIFO_DEPTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/oagu_fifo.sv
// rtl/oagu_fifo.sv - result buffer FIFO for the sort output AGU
// Purpose: synchronous FIFO, head entry presented combinationally from registers.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   flush        empty the FIFO (dominates push/pop)
//   push, din    write din when accepted
//   pop          drop head entry when not empty
//   dout         current head entry
//   full, empty  occupancy flags
module oagu_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  // One extra pointer bit distinguishes full from empty.
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign do_pop  = pop && !empty;
  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  assign dout = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage is cleared on reset so the write data port reads 0 out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push && !flush) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/oagu_sort.sv
// rtl/oagu_sort.sv - sort path output address generator
// Purpose: buffers sorted words from the npe sorter and writes them to consecutive
// IO buffer addresses, then signals completion to the scheduler.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   start_store                 scheduler pulse: latch config, (re)start a store
//   addr_start_o, out_piece     first write address, number of words (0..255)
//   i_sorter_valid/data         sorted result word from the npe
//   i_wr_gnt                    IO buffer write port grant
//   o_wr_en/addr/data           IO buffer write request
//   o_busy, o_store_done        store in progress, one-cycle completion pulse
//   o_overflow                  sticky: a result was dropped on a full FIFO
module oagu_sort
  import npu_sort_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int ADDR_W     = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_store,
  input  logic [ADDR_W-1:0] addr_start_o,
  input  logic [7:0]        out_piece,
  input  logic              i_sorter_valid,
  input  logic [DATA_W-1:0] i_sorter_data,
  input  logic              i_wr_gnt,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [DATA_W-1:0] o_wr_data,
  output logic              o_busy,
  output logic              o_store_done,
  output logic              o_overflow
);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        len_q;
  logic [7:0]        wr_cnt_q;
  logic [7:0]        push_cnt_q;
  logic              overflow_q;

  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_dout;
  logic              accept;
  logic              last_write;
  logic              want_push;
  logic              push;
  logic              drop;

  assign o_wr_en = (state == RUN) && !fifo_empty;
  assign accept  = o_wr_en && i_wr_gnt;
  assign last_write = accept && ((wr_cnt_q + 8'd1) == len_q);

  // Only words within the programmed length are taken; a restart cycle discards sorter data.
  assign want_push = (state == RUN) && !start_store && i_sorter_valid && (push_cnt_q != len_q);
  assign push      = want_push && !fifo_full;
  assign drop      = want_push && fifo_full;

  oagu_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (start_store),
    .push  (push),
    .pop   (accept),
    .din   (i_sorter_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start_store) begin
      state_nxt = (out_piece == 8'd0) ? DONE : RUN;
    end else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        RUN:     if (last_write) state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      len_q      <= '0;
      wr_cnt_q   <= '0;
      push_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else if (start_store) begin
      addr_q     <= addr_start_o;
      len_q      <= out_piece;
      wr_cnt_q   <= '0;
      push_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (accept) begin
        addr_q   <= addr_q + ADDR_W'(1);
        wr_cnt_q <= wr_cnt_q + 8'd1;
      end
      if (push) push_cnt_q <= push_cnt_q + 8'd1;
      if (drop) overflow_q <= 1'b1;
    end
  end

  assign o_wr_addr    = addr_q;
  assign o_wr_data    = fifo_dout;
  assign o_busy       = (state != IDLE);
  assign o_store_done = (state == DONE);
  assign o_overflow   = overflow_q;

endmodule

// File: tb/tb_oagu_sort.sv
// tb/tb_oagu_sort.sv - scoreboard bench for oagu_sort
module tb_oagu_sort;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_store;
  logic [12:0] addr_start_o;
  logic [7:0]  out_piece;
  logic        i_sorter_valid;
  logic [15:0] i_sorter_data;
  logic        i_wr_gnt;
  logic        o_wr_en;
  logic [12:0] o_wr_addr;
  logic [15:0] o_wr_data;
  logic        o_busy;
  logic        o_store_done;
  logic        o_overflow;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int d0;
  logic [12:0] exp_addr [$];
  logic [15:0] exp_data [$];
  logic [12:0] ea;
  logic [15:0] ed;

  oagu_sort dut (
    .clk            (clk),
    .rst            (rst),
    .start_store    (start_store),
    .addr_start_o   (addr_start_o),
    .out_piece      (out_piece),
    .i_sorter_valid (i_sorter_valid),
    .i_sorter_data  (i_sorter_data),
    .i_wr_gnt       (i_wr_gnt),
    .o_wr_en        (o_wr_en),
    .o_wr_addr      (o_wr_addr),
    .o_wr_data      (o_wr_data),
    .o_busy         (o_busy),
    .o_store_done   (o_store_done),
    .o_overflow     (o_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted write is compared against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && o_wr_en && i_wr_gnt) begin
      if (exp_addr.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none", o_wr_addr, o_wr_data);
      end else begin
        ea = exp_addr.pop_front();
        ed = exp_data.pop_front();
        check("wr_addr", 32'(o_wr_addr), 32'(ea));
        check("wr_data", 32'(o_wr_data), 32'(ed));
      end
    end
    if (!rst && o_store_done) done_cnt++;
  end

  task automatic start(input logic [12:0] a, input logic [7:0] n);
    @(posedge clk); #1;
    start_store = 1'b1; addr_start_o = a; out_piece = n;
    @(posedge clk); #1;
    start_store = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] d);
    i_sorter_valid = 1'b1; i_sorter_data = d;
    @(posedge clk); #1;
    i_sorter_valid = 1'b0;
  endtask

  task automatic expect_wr(input logic [12:0] a, input logic [15:0] d);
    exp_addr.push_back(a);
    exp_data.push_back(d);
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (o_store_done) begin seen = 1'b1; break; end
    end
    check(name, 32'(seen), 32'd1);
  endtask

  task automatic wait_empty(input string name);
    for (int k = 0; k < 60; k++) begin
      if (exp_addr.size() == 0) break;
      @(negedge clk);
    end
    check(name, 32'(exp_addr.size()), 32'd0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_wr_en"},   32'(o_wr_en), 32'd0);
    check({name, "_wr_addr"}, 32'(o_wr_addr), 32'd0);
    check({name, "_wr_data"}, 32'(o_wr_data), 32'd0);
    check({name, "_busy"},    32'(o_busy), 32'd0);
    check({name, "_done"},    32'(o_store_done), 32'd0);
    check({name, "_ovf"},     32'(o_overflow), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start_store = 1'b0; addr_start_o = '0; out_piece = '0;
    i_sorter_valid = 1'b0; i_sorter_data = '0; i_wr_gnt = 1'b0;
    repeat (2) @(posedge clk); #1;
    check_all_zero("reset");
    rst = 1'b0;

    // Basic store: 4 words to 0x0100.. with grant always high.
    i_wr_gnt = 1'b1;
    d0 = done_cnt;
    start(13'h0100, 8'd4);
    check("t1_busy_start", 32'(o_busy), 32'd1);
    check("t1_wr_en_start", 32'(o_wr_en), 32'd0);
    for (int i = 0; i < 4; i++) begin
      expect_wr(13'h0100 + 13'(i), 16'hA000 + 16'(i));
      send_word(16'hA000 + 16'(i));
      if (i == 0) check("t1_latency_wr_en", 32'(o_wr_en), 32'd1);
    end
    wait_done("t1_done");
    @(posedge clk); #1;
    check("t1_all_written", 32'(exp_addr.size()), 32'd0);
    check("t1_done_count", 32'(done_cnt - d0), 32'd1);
    check("t1_idle_busy", 32'(o_busy), 32'd0);

    // Grant withheld for 6 cycles during a 3-word burst.
    i_wr_gnt = 1'b0;
    d0 = done_cnt;
    start(13'h0100, 8'd3);
    for (int i = 0; i < 3; i++) begin
      expect_wr(13'h0100 + 13'(i), 16'hB000 + 16'(i));
      send_word(16'hB000 + 16'(i));
    end
    repeat (3) @(posedge clk); #1;
    check("t2_hold_wr_en", 32'(o_wr_en), 32'd1);
    check("t2_hold_addr", 32'(o_wr_addr), 32'h0100);
    check("t2_hold_data", 32'(o_wr_data), 32'hB000);
    i_wr_gnt = 1'b1;
    wait_done("t2_done");
    @(posedge clk); #1;
    check("t2_all_written", 32'(exp_addr.size()), 32'd0);
    check("t2_done_count", 32'(done_cnt - d0), 32'd1);

    // Overflow: 10 words into an 8-deep FIFO with no grant.
    i_wr_gnt = 1'b0;
    d0 = done_cnt;
    start(13'h0200, 8'd10);
    for (int i = 0; i < 10; i++) begin
      if (i < 8) expect_wr(13'h0200 + 13'(i), 16'hC000 + 16'(i));
      send_word(16'hC000 + 16'(i));
    end
    check("t3_overflow", 32'(o_overflow), 32'd1);
    check("t3_hold_addr", 32'(o_wr_addr), 32'h0200);
    i_wr_gnt = 1'b1;
    wait_empty("t3_eight_written");
    @(posedge clk); #1;
    check("t3_still_busy", 32'(o_busy), 32'd1);
    check("t3_drained", 32'(o_wr_en), 32'd0);
    check("t3_no_done", 32'(done_cnt - d0), 32'd0);

    // Restart from RUN with address wrap at the top of the address space.
    d0 = done_cnt;
    start(13'h1FFE, 8'd4);
    check("t4_overflow_cleared", 32'(o_overflow), 32'd0);
    expect_wr(13'h1FFE, 16'hD000);
    expect_wr(13'h1FFF, 16'hD001);
    expect_wr(13'h0000, 16'hD002);
    expect_wr(13'h0001, 16'hD003);
    for (int i = 0; i < 4; i++) send_word(16'hD000 + 16'(i));
    wait_done("t4_done");
    @(posedge clk); #1;
    check("t4_all_written", 32'(exp_addr.size()), 32'd0);
    check("t4_done_count", 32'(done_cnt - d0), 32'd1);

    // Sorter words while idle are ignored.
    send_word(16'hEEEE);
    send_word(16'hEEEF);
    check("idle_no_wr_en", 32'(o_wr_en), 32'd0);
    check("idle_no_overflow", 32'(o_overflow), 32'd0);
    check("idle_not_busy", 32'(o_busy), 32'd0);

    // Zero-length store: straight to DONE, one busy cycle.
    d0 = done_cnt;
    start(13'h0123, 8'd0);
    check("t5_done_pulse", 32'(o_store_done), 32'd1);
    check("t5_busy", 32'(o_busy), 32'd1);
    check("t5_no_wr", 32'(o_wr_en), 32'd0);
    @(posedge clk); #1;
    check("t5_done_end", 32'(o_store_done), 32'd0);
    check("t5_busy_end", 32'(o_busy), 32'd0);
    check("t5_done_count", 32'(done_cnt - d0), 32'd1);

    // Reset mid-store after 2 of 5 writes, then a fresh store.
    start(13'h0300, 8'd5);
    for (int i = 0; i < 2; i++) begin
      expect_wr(13'h0300 + 13'(i), 16'hF000 + 16'(i));
      send_word(16'hF000 + 16'(i));
    end
    wait_empty("t6_two_written");
    #2 rst = 1'b1;
    #1 check_all_zero("t6_rst");
    d0 = done_cnt;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("t6_no_done", 32'(done_cnt - d0), 32'd0);
    check("t6_idle", 32'(o_busy), 32'd0);
    start(13'h0400, 8'd2);
    for (int i = 0; i < 2; i++) begin
      expect_wr(13'h0400 + 13'(i), 16'h5A00 + 16'(i));
      send_word(16'h5A00 + 16'(i));
    end
    wait_done("t6_new_done");
    @(posedge clk); #1;
    check("t6_all_written", 32'(exp_addr.size()), 32'd0);
    check("t6_done_count", 32'(done_cnt - d0), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
